// File: rtl/arm_pkg.sv
// Shared constants for the ARM core front end: reset PC, PC stepping,
// the R15 read offset, and the bubble instruction used by flushed slots.
package arm_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] R15_OFFSET       = 32'd8;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_BRANCH,
        PC_WB
    } pc_sel_e;

    // Instruction fetches are word aligned; low address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and the rest of the core
// (hazard unit, execute/writeback redirects, imem, decode, counters).
interface fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             BranchTakenE;
    logic [31:0]      BranchTargetE;
    logic             PCSrcW;
    logic [31:0]      ResultW;
    logic [31:0]      InstrF;
    logic [31:0]      PCF;
    logic [31:0]      InstrD;
    logic [31:0]      PCD;
    logic [31:0]      PCPlus8D;
    logic             ValidD;
    logic [CNT_W-1:0] FetchCount;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        input  StallF, StallD, FlushD, BranchTakenE, BranchTargetE,
               PCSrcW, ResultW, InstrF,
        output PCF, InstrD, PCD, PCPlus8D, ValidD,
               FetchCount, StallCount, FlushCount
    );

    modport slave (
        output StallF, StallD, FlushD, BranchTakenE, BranchTargetE,
               PCSrcW, ResultW, InstrF,
        input  PCF, InstrD, PCD, PCPlus8D, ValidD,
               FetchCount, StallCount, FlushCount
    );

endinterface

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with synchronous reset.
module event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register with branch/writeback redirect, IF/ID pipeline
// register with stall/flush handling, and bring-up event counters.
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    pc_sel_e     pc_sel;
    logic [31:0] pcf_q;
    logic [31:0] pcf_next;
    logic [31:0] instr_d_q;
    logic [31:0] pc_d_q;
    logic        valid_d_q;
    logic        ifid_load;
    logic        stall_event;

    // Redirects outrank StallF so a stalled fetch never loses a branch.
    always_comb begin
        pc_sel = PC_SEQ;
        if (bus.BranchTakenE) begin
            pc_sel = PC_BRANCH;
        end else if (bus.PCSrcW) begin
            pc_sel = PC_WB;
        end else if (bus.StallF) begin
            pc_sel = PC_HOLD;
        end
    end

    always_comb begin
        pcf_next = pcf_q + PC_STEP;
        unique case (pc_sel)
            PC_BRANCH: pcf_next = align_word(bus.BranchTargetE);
            PC_WB:     pcf_next = align_word(bus.ResultW);
            PC_HOLD:   pcf_next = pcf_q;
            default:   pcf_next = pcf_q + PC_STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q <= RESET_PC;
        end else begin
            pcf_q <= pcf_next;
        end
    end

    assign ifid_load   = !bus.FlushD && !bus.StallD;
    assign stall_event = bus.StallF && !bus.BranchTakenE && !bus.PCSrcW;

    // Flush keeps PCD so the bubble still carries a traceable address.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d_q <= NOP_INSTR;
            pc_d_q    <= '0;
            valid_d_q <= 1'b0;
        end else if (bus.FlushD) begin
            instr_d_q <= NOP_INSTR;
            valid_d_q <= 1'b0;
        end else if (ifid_load) begin
            instr_d_q <= bus.InstrF;
            pc_d_q    <= pcf_q;
            valid_d_q <= 1'b1;
        end
    end

    assign bus.PCF      = pcf_q;
    assign bus.InstrD   = instr_d_q;
    assign bus.PCD      = pc_d_q;
    assign bus.ValidD   = valid_d_q;
    assign bus.PCPlus8D = pc_d_q + R15_OFFSET;

    event_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifid_load),
        .count (bus.FetchCount)
    );

    event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_event),
        .count (bus.StallCount)
    );

    event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.FlushD),
        .count (bus.FlushCount)
    );

endmodule
